// File: rtl/dmem_line_server_pkg.sv
// Shared definitions for the line-fill data memory: line geometry, fill FSM states
// and small address/byte helpers used by the server, its array and its interface.
package dmem_line_server_pkg;

    localparam int LINE_WORDS     = 4;
    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS      = LINE_WORDS * WORD_BITS;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fill_state_e;

    // Array sizes need not be powers of two, so indices wrap with a true modulo.
    function automatic logic [31:0] mod_index(logic [31:0] idx, logic [31:0] modulus);
        return idx % modulus;
    endfunction

    function automatic word_t merge_bytes(word_t old_w, word_t new_w,
                                          logic [BYTES_PER_WORD-1:0] be);
        word_t r;
        r = old_w;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_line_server_if.sv
// Write port and line-fill request/response bundle of dmem_line_server.
// The wbe byte-enable lane exists only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_line_server_if;
    import dmem_line_server_pkg::*;

    logic        we;
    logic [31:0] waddr;
    word_t       wdata;
`ifdef DMEM_BYTE_WRITE_EN
    logic [BYTES_PER_WORD-1:0] wbe;
`endif
    logic        req;
    logic [31:0] raddr;
    logic        busy;
    logic        ready;
    line_t       line;

`ifdef DMEM_BYTE_WRITE_EN
    modport master (output we, waddr, wdata, wbe, req, raddr,
                    input  busy, ready, line);
    modport slave  (input  we, waddr, wdata, wbe, req, raddr,
                    output busy, ready, line);
`else
    modport master (output we, waddr, wdata, req, raddr,
                    input  busy, ready, line);
    modport slave  (input  we, waddr, wdata, req, raddr,
                    output busy, ready, line);
`endif

endinterface

// File: rtl/dmem_word_array.sv
// Word storage for dmem_line_server: one synchronous word write port and one
// combinational four-word line read port. Byte enables with DMEM_BYTE_WRITE_EN.
module dmem_word_array
    import dmem_line_server_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LIDX_W      = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [31:0]       waddr_i,
    input  word_t             wdata_i,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [BYTES_PER_WORD-1:0] wbe_i,
`endif
    input  logic [LIDX_W-1:0] rd_line_idx_i,
    output line_t             rd_line_o
);

    localparam int WIDX_W = $clog2(DEPTH_WORDS);

    word_t             mem_q [DEPTH_WORDS];
    logic [WIDX_W-1:0] widx;
    logic [WIDX_W-1:0] rbase;
    logic [1:0]        unused_wbyte;

    assign unused_wbyte = waddr_i[1:0];
    assign widx  = WIDX_W'(mod_index({2'b00, waddr_i[31:2]}, 32'(DEPTH_WORDS)));
    assign rbase = WIDX_W'({rd_line_idx_i, 2'b00});

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
`ifdef DMEM_BYTE_WRITE_EN
            mem_q[widx] <= merge_bytes(mem_q[widx], wdata_i, wbe_i);
`else
            mem_q[widx] <= wdata_i;
`endif
        end
    end

    always_comb begin
        rd_line_o = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            rd_line_o[w*WORD_BITS +: WORD_BITS] = mem_q[rbase + WIDX_W'(w)];
        end
    end

endmodule

// File: rtl/dmem_line_server.sv
// Fixed-latency cache line server: accepts one fill at a time, answers LATENCY cycles
// later with a one-cycle ready pulse. Optional byte writes via DMEM_BYTE_WRITE_EN.
module dmem_line_server
    import dmem_line_server_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input logic               clk,
    input logic               rst,
    dmem_line_server_if.slave bus
);

    localparam int LIDX_W = (DEPTH_WORDS > LINE_WORDS) ? $clog2(DEPTH_WORDS / LINE_WORDS) : 1;
    localparam int CNT_W  = 4;

    fill_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LIDX_W-1:0] lidx_q;
    line_t             line_q;
    line_t             rd_line;
    logic [LIDX_W-1:0] req_lidx;
    logic [3:0]        unused_raddr_lsb;

    assign unused_raddr_lsb = bus.raddr[3:0];
    assign req_lidx = LIDX_W'(mod_index({4'b0000, bus.raddr[31:4]},
                                        32'(DEPTH_WORDS / LINE_WORDS)));

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LIDX_W      (LIDX_W)
    ) u_array (
        .clk           (clk),
        .we_i          (bus.we),
        .waddr_i       (bus.waddr),
        .wdata_i       (bus.wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .wbe_i         (bus.wbe),
`endif
        .rd_line_idx_i (lidx_q),
        .rd_line_o     (rd_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_q <= ST_RESP;
                end
                ST_RESP: begin
                    line_q  <= rd_line;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The line index is payload, only meaningful while a fill is pending.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.req) lidx_q <= req_lidx;
    end

    // During RESP the line reads the array live, so writes landing on the edge into RESP are seen.
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.ready = (state_q == ST_RESP);
    assign bus.line  = (state_q == ST_RESP) ? rd_line : line_q;

endmodule

// File: doc/dmem_line_server.md
DMEM_LINE_SERVER -- requirements
Module: dmem_line_server

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, data words stored (multiple of 4).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from accepted request to line response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port we  input  1  word write strobe.
REQ-006 SHALL have port waddr  input  32  byte address of write.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port req  input  1  line-fill request from the cache.
REQ-009 SHALL have port raddr  input  32  byte address within the requested line.
REQ-010 SHALL have port busy  output  1  fill in progress; new req ignored.
REQ-011 SHALL have port ready  output  1  single-cycle line-valid pulse.
REQ-012 SHALL have port line  output  128  returned line, word 0 in bits [31:0], word 3 in [127:96].

Function
REQ-013 SHALL decode word index = addr[31:2] modulo DEPTH_WORDS and line index = addr[31:4] modulo DEPTH_WORDS/4; addr[1:0] ignored.
REQ-014 SHALL commit a write on every rising edge with we=1, in any FSM state, including during a fill.
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-016 SHALL, in IDLE with req=1, latch raddr's line index, load the down-counter with LATENCY-1, and go to WAIT (straight to RESP if LATENCY=1).
REQ-017 SHALL decrement the counter each WAIT cycle and go to RESP when it reaches 0.
REQ-018 SHALL, in RESP, assert ready=1 for exactly one cycle, with line driven from array contents as of that cycle, then return to IDLE.
REQ-019 SHALL start ready exactly LATENCY cycles after the accepting edge: req sampled at edge N gives ready high during cycle N+LATENCY.
REQ-020 SHALL hold busy=1 in WAIT and RESP and 0 in IDLE; req seen while busy=1 SHALL be dropped, not queued.
REQ-021 SHALL include in the returned line any write committed at or before the edge entering RESP, including a write in the same cycle as the accepted req.
REQ-022 SHALL hold line at its last returned value when ready=0.
REQ-023 SHALL allow back-to-back fills: a req in the IDLE cycle right after RESP is accepted.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, counter 0, busy=0, ready=0, line=0 immediately (asynchronously).
REQ-025 SHALL abort any in-flight fill on reset mid-operation with no ready pulse, even if reset falls before the original response cycle.
REQ-026 SHALL NOT clear array contents on reset; initial contents are undefined unless preloaded by the bench.

Configuration
REQ-027 SHALL recognise macro DMEM_BYTE_WRITE_EN; when defined, add port wbe  input  4  byte enables, and a write updates only bytes whose wbe bit is 1 (wbe[0] -> bits [7:0]).
REQ-028 SHALL, without DMEM_BYTE_WRITE_EN, have no wbe port, and every write SHALL replace the full 32-bit word.

Structure
REQ-029 SHALL take LINE_WORDS=4, LINE_BITS=128, WORD_BITS=32 and the FSM state enum from the shared pipeline package.
REQ-030 SHALL use one sub-module, dmem_word_array: the storage array, with a synchronous write port and a combinational 4-word line read port.

Verification
REQ-031 SHALL cover this case: preload words 0x40..0x4C = 1,2,3,4; LATENCY=4; req at edge 0 with raddr=0x48 -> ready high only in cycle 4, line=0x00000004_00000003_00000002_00000001, busy high in cycles 1-4.
REQ-032 SHALL cover this case: fill of line 0x40 in progress; write 0xDEADBEEF to 0x44 at cycle 2 -> returned line[63:32]=0xDEADBEEF.
REQ-033 SHALL cover this case: second req at cycle 2 during a fill -> dropped, exactly one ready pulse; req in the cycle after RESP -> accepted, ready LATENCY cycles later.
REQ-034 SHALL cover this case: rst pulsed in cycle 2 of a fill -> busy/ready/line=0 immediately, no ready pulse afterwards, array data intact on a later fill.
REQ-035 SHALL cover this case: LATENCY=1 -> ready in the cycle after the accepting edge; raddr=DEPTH_WORDS*4+0x40 wraps to line 0x40.
REQ-036 SHALL cover this case: with DMEM_BYTE_WRITE_EN, write 0xAABBCCDD, wbe=4'b0101 over 0x11223344 -> later fill shows 0x11BB33DD.
